// File: rtl/hci_package.sv
// Shared HCI streamer command/flag types and the command arbiter state encoding.
package hci_package;

   localparam int unsigned HCI_ADDR_W = 32;
   localparam int unsigned HCI_LEN_W  = 32;

   typedef struct packed {
      logic [HCI_ADDR_W-1:0] base_addr;
      logic [HCI_LEN_W-1:0]  tot_len;
      logic [HCI_ADDR_W-1:0] d0_stride;
   } hci_streamer_addressgen_ctrl_t;

   typedef struct packed {
      logic in_progress;
      logic last_beat;
   } hci_streamer_addressgen_flags_t;

   typedef struct packed {
      logic                          req_start;
      hci_streamer_addressgen_ctrl_t addressgen_ctrl;
   } hci_streamer_ctrl_t;

   typedef struct packed {
      logic                           ready_start;
      logic                           done;
      hci_streamer_addressgen_flags_t addressgen_flags;
   } hci_streamer_flags_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_BUSY  = 2'd2
   } hci_cmd_arb_state_t;

endpackage

// File: rtl/hci_core_cmd_arbiter_rr.sv
// Combinational round-robin select: first requester at or after rr_ptr, wrapping.
module hci_core_cmd_arbiter_rr #(
   parameter int unsigned NB_REQ = 2,
   parameter int unsigned ID_W   = $clog2(NB_REQ)
) (
   input  logic [NB_REQ-1:0] req,
   input  logic [ID_W-1:0]   rr_ptr,
   output logic [ID_W-1:0]   w,
   output logic              valid
);

   // Scan offsets 0..NB_REQ-1 from the pointer; first hit wins.
   always_comb begin
      int unsigned idx;
      valid = 1'b0;
      w     = '0;
      idx   = 0;
      for (int unsigned i = 0; i < NB_REQ; i++) begin
         idx = (32'(rr_ptr) + i) % NB_REQ;
         for (int unsigned k = 0; k < NB_REQ; k++) begin
            if (!valid && (k == idx) && req[k]) begin
               valid = 1'b1;
               w     = ID_W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/hci_core_cmd_arbiter.sv
// Round-robin owner of a shared HCI streamer: grants one requester, issues its
// registered command, and routes completion flags back to that requester only.
module hci_core_cmd_arbiter
   import hci_package::*;
#(
   parameter int unsigned NB_REQ = 2,
   parameter int unsigned ID_W   = $clog2(NB_REQ)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clear_i,
   input  logic                enable_i,
   input  hci_streamer_ctrl_t  ctrl_i  [NB_REQ],
   output hci_streamer_flags_t flags_o [NB_REQ],
   output hci_streamer_ctrl_t  ctrl_o,
   input  hci_streamer_flags_t flags_i,
   output logic [ID_W-1:0]     owner_o,
   output logic                busy_o
);

   hci_cmd_arb_state_t            state_q, state_d;
   logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]               owner_q, owner_d;
   hci_streamer_addressgen_ctrl_t cmd_q, cmd_d;
   logic [NB_REQ-1:0]             req_vec;
   logic [ID_W-1:0]               win;
   logic                          win_valid;

   // Gather request strobes into a vector for the selector.
   always_comb begin
      req_vec = '0;
      for (int unsigned k = 0; k < NB_REQ; k++) begin
         req_vec[k] = ctrl_i[k].req_start;
      end
   end

   hci_core_cmd_arbiter_rr #(
      .NB_REQ (NB_REQ),
      .ID_W   (ID_W)
   ) u_rr (
      .req    (req_vec),
      .rr_ptr (rr_ptr_q),
      .w      (win),
      .valid  (win_valid)
   );

   // State, pointer, owner and command registers; clear behaves like reset.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         cmd_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         cmd_q    <= cmd_d;
      end
   end

   // Next-state logic and per-requester flag routing.
   always_comb begin
      state_d                = state_q;
      rr_ptr_d               = rr_ptr_q;
      owner_d                = owner_q;
      cmd_d                  = cmd_q;
      ctrl_o.req_start       = 1'b0;
      ctrl_o.addressgen_ctrl = cmd_q;
      for (int unsigned k = 0; k < NB_REQ; k++) begin
         flags_o[k] = '0;
      end

      unique case (state_q)
         ARB_IDLE: begin
            if (enable_i && win_valid) begin
               for (int unsigned k = 0; k < NB_REQ; k++) begin
                  if (ID_W'(k) == win) begin
                     flags_o[k].ready_start = 1'b1;
                     cmd_d                  = ctrl_i[k].addressgen_ctrl;
                  end
               end
               owner_d = win;
               state_d = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            if (flags_i.ready_start) begin
               ctrl_o.req_start = 1'b1;
               state_d          = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            for (int unsigned k = 0; k < NB_REQ; k++) begin
               if (ID_W'(k) == owner_q) begin
                  flags_o[k].addressgen_flags = flags_i.addressgen_flags;
                  flags_o[k].done             = flags_i.done;
               end
            end
            if (flags_i.done) begin
               rr_ptr_d = (owner_q == ID_W'(NB_REQ - 1)) ? '0 : owner_q + ID_W'(1);
               state_d  = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      // An abandoned command must not leak pulses to requesters or the streamer.
      if (rst_i || clear_i) begin
         ctrl_o.req_start = 1'b0;
         for (int unsigned k = 0; k < NB_REQ; k++) begin
            flags_o[k] = '0;
         end
      end
   end

   assign owner_o = owner_q;
   assign busy_o  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_hci_core_cmd_arbiter.sv
// Directed bench for hci_core_cmd_arbiter: a 2-requester and a 3-requester instance.
module tb_hci_core_cmd_arbiter;
   import hci_package::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic                en2, clr2;
   hci_streamer_ctrl_t  ctrl2    [2];
   hci_streamer_flags_t flags_o2 [2];
   hci_streamer_ctrl_t  ctrl_o2;
   hci_streamer_flags_t flags_i2;
   logic [0:0]          owner2;
   logic                busy2;

   logic                en3, clr3;
   hci_streamer_ctrl_t  ctrl3    [3];
   hci_streamer_flags_t flags_o3 [3];
   hci_streamer_ctrl_t  ctrl_o3;
   hci_streamer_flags_t flags_i3;
   logic [1:0]          owner3;
   logic                busy3;

   hci_core_cmd_arbiter #(.NB_REQ(2)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .clear_i(clr2), .enable_i(en2),
      .ctrl_i(ctrl2), .flags_o(flags_o2), .ctrl_o(ctrl_o2),
      .flags_i(flags_i2), .owner_o(owner2), .busy_o(busy2)
   );

   hci_core_cmd_arbiter #(.NB_REQ(3)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .clear_i(clr3), .enable_i(en3),
      .ctrl_i(ctrl3), .flags_o(flags_o3), .ctrl_o(ctrl_o3),
      .flags_i(flags_i3), .owner_o(owner3), .busy_o(busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr2 = 1'b0; clr3 = 1'b0; en2 = 1'b1; en3 = 1'b1;
      flags_i2 = '0; flags_i3 = '0;
      for (int k = 0; k < 2; k++) ctrl2[k] = '0;
      for (int k = 0; k < 3; k++) ctrl3[k] = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++; if (ctrl_o2 !== '0) begin failures++; $display("FAIL reset_ctrl_o got=%h exp=0", ctrl_o2); end
      checks++; if (flags_o2[0] !== '0 || flags_o2[1] !== '0) begin failures++; $display("FAIL reset_flags_o got=%h/%h exp=0", flags_o2[0], flags_o2[1]); end
      checks++; if (owner2 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL reset_owner_busy got=%b/%b exp=0/0", owner2, busy2); end
      checks++; if (busy3 !== 1'b0 || owner3 !== 2'd0) begin failures++; $display("FAIL reset_dut3 got busy=%b owner=%0d exp=0/0", busy3, owner3); end
   endtask

   task automatic test_single();
      flags_i2.ready_start = 1'b1;
      ctrl2[0].req_start = 1'b1;
      ctrl2[0].addressgen_ctrl.base_addr = 32'h100;
      #1;
      checks++; if (flags_o2[0].ready_start !== 1'b1 || flags_o2[1].ready_start !== 1'b0) begin failures++; $display("FAIL single_accept got=%b%b exp=01", flags_o2[1].ready_start, flags_o2[0].ready_start); end
      checks++; if (busy2 !== 1'b0 || ctrl_o2.req_start !== 1'b0) begin failures++; $display("FAIL single_grant_cycle got busy=%b req=%b exp=0/0", busy2, ctrl_o2.req_start); end
      tick();
      ctrl2[0].req_start = 1'b0;
      #1;
      checks++; if (ctrl_o2.req_start !== 1'b1 || ctrl_o2.addressgen_ctrl.base_addr !== 32'h100) begin failures++; $display("FAIL single_issue got req=%b base=%h exp=1/100", ctrl_o2.req_start, ctrl_o2.addressgen_ctrl.base_addr); end
      checks++; if (busy2 !== 1'b1 || owner2 !== 1'b0) begin failures++; $display("FAIL single_busy got busy=%b owner=%0d exp=1/0", busy2, owner2); end
      tick();
      checks++; if (ctrl_o2.req_start !== 1'b0 || ctrl_o2.addressgen_ctrl.base_addr !== 32'h100) begin failures++; $display("FAIL single_busy_ctrl got req=%b base=%h exp=0/100", ctrl_o2.req_start, ctrl_o2.addressgen_ctrl.base_addr); end
      for (int i = 0; i < 9; i++) tick();
      flags_i2.done = 1'b1;
      #1;
      checks++; if (flags_o2[0].done !== 1'b1 || flags_o2[1].done !== 1'b0) begin failures++; $display("FAIL single_done got=%b%b exp=01", flags_o2[1].done, flags_o2[0].done); end
      tick();
      flags_i2.done = 1'b0;
      #1;
      checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%b exp=0", busy2); end
   endtask

   task automatic test_backpressure_isolation();
      flags_i2.ready_start = 1'b0;
      ctrl2[1].req_start = 1'b1;
      ctrl2[1].addressgen_ctrl.base_addr = 32'h180;
      #1;
      checks++; if (flags_o2[1].ready_start !== 1'b1 || flags_o2[0].ready_start !== 1'b0) begin failures++; $display("FAIL bp_accept got=%b%b exp=10", flags_o2[1].ready_start, flags_o2[0].ready_start); end
      tick();
      ctrl2[1].req_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (ctrl_o2.req_start !== 1'b0 || busy2 !== 1'b1) begin failures++; $display("FAIL bp_stall%0d got req=%b busy=%b exp=0/1", i, ctrl_o2.req_start, busy2); end
         tick();
      end
      flags_i2.ready_start = 1'b1;
      #1;
      checks++; if (ctrl_o2.req_start !== 1'b1 || ctrl_o2.addressgen_ctrl.base_addr !== 32'h180) begin failures++; $display("FAIL bp_release got req=%b base=%h exp=1/180", ctrl_o2.req_start, ctrl_o2.addressgen_ctrl.base_addr); end
      tick();
      checks++; if (ctrl_o2.req_start !== 1'b0 || busy2 !== 1'b1 || owner2 !== 1'b1) begin failures++; $display("FAIL bp_busy got req=%b busy=%b owner=%0d exp=0/1/1", ctrl_o2.req_start, busy2, owner2); end
      flags_i2.addressgen_flags.in_progress = 1'b1;
      flags_i2.addressgen_flags.last_beat   = 1'b1;
      #1;
      checks++; if (flags_o2[0] !== '0) begin failures++; $display("FAIL iso_nonowner got=%h exp=0", flags_o2[0]); end
      checks++; if (flags_o2[1].addressgen_flags !== 2'b11) begin failures++; $display("FAIL iso_owner_agflags got=%b exp=11", flags_o2[1].addressgen_flags); end
      flags_i2.done = 1'b1;
      #1;
      checks++; if (flags_o2[1].done !== 1'b1 || flags_o2[0].done !== 1'b0) begin failures++; $display("FAIL iso_done got=%b%b exp=10", flags_o2[1].done, flags_o2[0].done); end
      tick();
      flags_i2.addressgen_flags = '0;
      #1;
      checks++; if (flags_o2[0].done !== 1'b0 || flags_o2[1].done !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL spurious_done got=%b%b busy=%b exp=00/0", flags_o2[1].done, flags_o2[0].done, busy2); end
      tick();
      flags_i2.done = 1'b0;
      #1;
      checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL spurious_idle got=%b exp=0", busy2); end
   endtask

   task automatic test_enable();
      en2 = 1'b0;
      ctrl2[1].req_start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (flags_o2[1].ready_start !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL en_gate%0d got rs=%b busy=%b exp=0/0", i, flags_o2[1].ready_start, busy2); end
         tick();
      end
      en2 = 1'b1;
      #1;
      checks++; if (flags_o2[1].ready_start !== 1'b1) begin failures++; $display("FAIL en_grant got=%b exp=1", flags_o2[1].ready_start); end
      tick();
      ctrl2[1].req_start = 1'b0;
      #1;
      checks++; if (ctrl_o2.req_start !== 1'b1) begin failures++; $display("FAIL en_issue got=%b exp=1", ctrl_o2.req_start); end
      tick();
      en2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL en_busy_hold%0d got=%b exp=1", i, busy2); end
         tick();
      end
      flags_i2.done = 1'b1;
      #1;
      checks++; if (flags_o2[1].done !== 1'b1) begin failures++; $display("FAIL en_done got=%b exp=1", flags_o2[1].done); end
      tick();
      flags_i2.done = 1'b0;
      en2 = 1'b1;
   endtask

   task automatic test_back_to_back();
      ctrl2[0].req_start = 1'b1;
      ctrl2[1].req_start = 1'b1;
      #1;
      checks++; if (flags_o2[0].ready_start !== 1'b1 || flags_o2[1].ready_start !== 1'b0) begin failures++; $display("FAIL wrap_grant0 got=%b%b exp=01", flags_o2[1].ready_start, flags_o2[0].ready_start); end
      tick(); tick();
      flags_i2.done = 1'b1;
      tick();
      flags_i2.done = 1'b0;
      #1;
      checks++; if (flags_o2[1].ready_start !== 1'b1 || flags_o2[0].ready_start !== 1'b0) begin failures++; $display("FAIL b2b_grant1 got=%b%b exp=10", flags_o2[1].ready_start, flags_o2[0].ready_start); end
      tick(); tick();
      flags_i2.done = 1'b1;
      tick();
      flags_i2.done = 1'b0;
      #1;
      checks++; if (flags_o2[0].ready_start !== 1'b1 || flags_o2[1].ready_start !== 1'b0) begin failures++; $display("FAIL b2b_grant0 got=%b%b exp=01", flags_o2[1].ready_start, flags_o2[0].ready_start); end
      ctrl2[1].req_start = 1'b0;
      tick();
      ctrl2[0].req_start = 1'b0;
      tick();
      flags_i2.done = 1'b1;
      tick();
      flags_i2.done = 1'b0;
   endtask

   task automatic test_clear();
      ctrl2[1].req_start = 1'b1;
      ctrl2[1].addressgen_ctrl.base_addr = 32'h200;
      #1;
      checks++; if (flags_o2[1].ready_start !== 1'b1) begin failures++; $display("FAIL clr_grant got=%b exp=1", flags_o2[1].ready_start); end
      tick();
      ctrl2[1].req_start = 1'b0;
      tick();
      checks++; if (busy2 !== 1'b1 || ctrl_o2.addressgen_ctrl.base_addr !== 32'h200) begin failures++; $display("FAIL clr_pre got busy=%b base=%h exp=1/200", busy2, ctrl_o2.addressgen_ctrl.base_addr); end
      clr2 = 1'b1;
      tick();
      clr2 = 1'b0;
      #1;
      checks++; if (busy2 !== 1'b0 || ctrl_o2 !== '0 || owner2 !== 1'b0) begin failures++; $display("FAIL clr_state got busy=%b ctrl=%h owner=%0d exp=0/0/0", busy2, ctrl_o2, owner2); end
      flags_i2.done = 1'b1;
      #1;
      checks++; if (flags_o2[0] !== '0 || flags_o2[1] !== '0) begin failures++; $display("FAIL clr_late_done got=%h/%h exp=0", flags_o2[0], flags_o2[1]); end
      tick();
      flags_i2.done = 1'b0;
      ctrl2[0].req_start = 1'b1;
      ctrl2[1].req_start = 1'b1;
      #1;
      checks++; if (flags_o2[0].ready_start !== 1'b1 || flags_o2[1].ready_start !== 1'b0) begin failures++; $display("FAIL clr_rrptr got=%b%b exp=01", flags_o2[1].ready_start, flags_o2[0].ready_start); end
      tick();
      ctrl2[0].req_start = 1'b0;
      ctrl2[1].req_start = 1'b0;
   endtask

   task automatic test_fairness();
      int exp_id;
      int found;
      int n;
      int prev;
      prev = -1;
      flags_i3.ready_start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ctrl3[k].req_start = 1'b1;
         ctrl3[k].addressgen_ctrl.base_addr = 32'h1000 + 32'(k);
      end
      for (int g = 0; g < 6; g++) begin
         exp_id = g % 3;
         #1;
         found = -1; n = 0;
         for (int k = 0; k < 3; k++) begin
            if (flags_o3[k].ready_start === 1'b1) begin found = k; n++; end
         end
         checks++; if (found != exp_id || n != 1 || found == prev) begin failures++; $display("FAIL fair_grant%0d got=%0d pulses=%0d prev=%0d exp=%0d", g, found, n, prev, exp_id); end
         prev = found;
         tick();
         checks++; if (owner3 !== 2'(exp_id) || ctrl_o3.addressgen_ctrl.base_addr !== 32'h1000 + 32'(exp_id)) begin failures++; $display("FAIL fair_owner%0d got=%0d base=%h exp=%0d", g, owner3, ctrl_o3.addressgen_ctrl.base_addr, exp_id); end
         tick();
         flags_i3.done = 1'b1;
         #1;
         checks++; if (flags_o3[exp_id].done !== 1'b1) begin failures++; $display("FAIL fair_done%0d got=%b exp=1", g, flags_o3[exp_id].done); end
         tick();
         flags_i3.done = 1'b0;
      end
      for (int k = 0; k < 3; k++) ctrl3[k].req_start = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_single();
      test_backpressure_isolation();
      test_enable();
      test_back_to_back();
      test_clear();
      test_fairness();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hci_core_cmd_arbiter.md
# hci_core_cmd_arbiter

Round-robin scheduler that shares one HCI core streamer (source or sink) between `NB_REQ` command issuers. Each requester presents a streamer command (`hci_streamer_ctrl_t`). The arbiter grants one requester at a time, registers that requester's command and issues it to the streamer. It owns the streamer until `done`, then routes completion and address-generator flags back to the owning requester only. It sits between engine control FSMs or per-requester command queues and the single streamer instance.

## Interface
Parameters:
- `NB_REQ`, default 2: number of requesters; must be ≥ 2.
- `ID_W`, default `$clog2(NB_REQ)`: owner index width; derived, not overridden.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `clear_i`  in  1  synchronous soft clear; same effect as `rst_i`.
- `enable_i`  in  1  when low, no new grant is made; a command already in flight completes normally.
- `ctrl_i[NB_REQ]`  in  `hci_streamer_ctrl_t`  per-requester command; uses `req_start` and `addressgen_ctrl`.
- `flags_o[NB_REQ]`  out  `hci_streamer_flags_t`  per-requester flags: `ready_start`, `done`, `addressgen_flags`.
- `ctrl_o`  out  `hci_streamer_ctrl_t`  command to the shared streamer.
- `flags_i`  in  `hci_streamer_flags_t`  flags from the shared streamer.
- `owner_o`  out  `ID_W`  index of the current or last owner (debug/perf).
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, BUSY.
- IDLE:
  - If `enable_i` is high and any `ctrl_i[k].req_start` is high, select winner `w` = first requesting index at or after `rr_ptr`, wrapping modulo `NB_REQ`.
  - Same cycle: `flags_o[w].ready_start`=1 (acceptance pulse). Register `cmd_q` ← `ctrl_i[w].addressgen_ctrl` and `owner_q` ← `w`. Next state: ISSUE.
  - Requesters may drop `req_start` after the acceptance pulse.
- ISSUE:
  - `ctrl_o.req_start`=1 while `flags_i.ready_start`=1; `ctrl_o.addressgen_ctrl`=`cmd_q` in all states.
  - When `ctrl_o.req_start` is high, next state is BUSY. Otherwise remain in ISSUE (wait for the streamer to become ready).
- BUSY:
  - `flags_o[owner_q].addressgen_flags` = `flags_i.addressgen_flags`.
  - On `flags_i.done`: `flags_o[owner_q].done`=1 in the same cycle (combinational). Set `rr_ptr` ← `(owner_q+1) mod NB_REQ`. Next state: IDLE.
- Non-owners always see `ready_start`=0, `done`=0 and `addressgen_flags`=0. In IDLE and ISSUE, all `flags_o[*].addressgen_flags`=0.
- `flags_i.done` outside BUSY is ignored.
- `ctrl_o.req_start` is 0 in IDLE and BUSY.
- Wrap: when `rr_ptr`=`NB_REQ-1` and `owner_q`=`NB_REQ-1`, `rr_ptr` becomes 0. For non-power-of-2 `NB_REQ`, `rr_ptr` never exceeds `NB_REQ-1`.
- `enable_i` deasserted in ISSUE or BUSY has no effect on the current command.
- `rst_i` or `clear_i` in any state: next state IDLE, `rr_ptr`=0, `owner_q`=0, `cmd_q`=0. The in-flight command is abandoned; no `done` is forwarded. `clear_i` has priority over all transitions.

## Timing
- Reset values: `ctrl_o`='0, all `flags_o`='0, `owner_o`=0, `busy_o`=0.
- Grant latency: request at cycle t in IDLE → acceptance pulse at t → `ctrl_o.req_start` at t+1 at the earliest.
- Completion latency: `flags_i.done` at cycle d → `flags_o[owner].done` at d (0-cycle). Next grant is possible at d+1 (one IDLE cycle minimum between commands).
- Minimum occupancy per command: 3 cycles (IDLE, ISSUE, BUSY).
- A request arriving in the same cycle as `done`: it is arbitrated at d+1 with the updated `rr_ptr`.
- All state registers update only on the `clk_i` rising edge; there are no combinational paths from `ctrl_i` to `ctrl_o`.

## Structure
- `hci_streamer_ctrl_t` and `hci_streamer_flags_t` come from `hci_package`. Add `hci_cmd_arb_state_t` (enum IDLE/ISSUE/BUSY) to `hci_package`.
- Sub-module `hci_core_cmd_arbiter_rr`: combinational round-robin priority select. Inputs: request vector and `rr_ptr`. Outputs: `w` and a `valid` flag.
- `hci_core_cmd_queue` may be instantiated per requester upstream; this block adds no buffering beyond `cmd_q`.

## Test plan
- Single request: `NB_REQ`=2, req0 with `base_addr`=0x100; streamer ready → acceptance pulse at t, `ctrl_o.req_start` at t+1 with `base_addr` 0x100; `done` 10 cycles later → `flags_o[0].done` in the same cycle, `busy_o` falls the next cycle.
- Fairness: `NB_REQ`=3, all three request continuously → grant order 0,1,2,0,1,2; no requester is granted twice in a row.
- Backpressure: `flags_i.ready_start`=0 for 5 cycles in ISSUE → `ctrl_o.req_start`=0 and FSM stays in ISSUE; `ready_start` rises → issue occurs that cycle and FSM moves to BUSY.
- Flag isolation: owner 1 in BUSY with `flags_i.addressgen_flags` nonzero → `flags_o[0]` all zero; spurious `flags_i.done` in IDLE → no `flags_o.done` pulse.
- Enable gating: `enable_i`=0 with req1 pending → no grant; `enable_i` rises → grant at that cycle. Dropping `enable_i` during BUSY does not abort the command.
- Clear mid-operation: `clear_i` pulse in BUSY → IDLE next cycle, all outputs 0, `rr_ptr`=0; a later `flags_i.done` is ignored.
